// File: rtl/ascon_dec_ctrl.sv
// Ascon-128 decryption sequencer: one AD block, one CT block, tag check.
// Plaintext is only released after a constant-time tag compare succeeds.

module ascon_dec_ctrl #(
  parameter int pTIMEOUT  = 4096,
  parameter int pTO_WIDTH = 13
) (
  input  logic           crypto_clk,
  input  logic           reset_i,
  input  logic           I_start,
  input  logic [127:0]   I_ad,
  input  logic [127:0]   I_ct,
  input  logic [127:0]   I_tag,
  input  logic [4:0]     I_ad_bytes,
  input  logic [4:0]     I_ct_bytes,
  output logic [127:0]   O_core_data,
  output logic [4:0]     O_core_bytes,
  output logic           O_core_valid,
  output logic           O_core_last,
  output logic           O_core_eot,
  output logic           O_core_key_valid,
  output logic           O_core_decrypt,
  input  logic           I_core_ready_for_data,
  input  logic           I_core_read_data,
  input  logic           I_core_out_valid,
  input  logic [127:0]   I_core_out,
  input  logic           I_core_ready_tag,
  input  logic [127:0]   I_core_tag,
  output logic [127:0]   O_pt,
  output logic [4:0]     O_pt_bytes,
  output logic           O_busy,
  output logic           O_done,
  output logic           O_tag_ok,
  output logic           O_err,
  output logic           O_trigger
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD,
    S_MSG,
    S_WAIT_TAG,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [pTO_WIDTH-1:0] TO_MAX = pTO_WIDTH'(pTIMEOUT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [pTO_WIDTH-1:0]   to_cnt;
  logic [127:0]           ad_q;
  logic [127:0]           ct_q;
  logic [127:0]           tag_rx_q;
  logic [127:0]           tag_core_q;
  logic [127:0]           pt_q;
  logic [4:0]             ad_bytes_q;
  logic                   bad_len;
  logic                   waiting;
  logic                   timeout;
  logic                   to_fire;
  logic                   mismatch;
  logic [7:0]             mask_sh;
  logic [127:0]           pt_mask;

  assign bad_len  = (I_ad_bytes > 5'd16) | (I_ct_bytes > 5'd16);
  assign waiting  = (state == S_INIT) | (state == S_AD)
                  | (state == S_MSG)  | (state == S_WAIT_TAG);
  assign timeout  = waiting & (to_cnt == TO_MAX);
  assign to_fire  = timeout & (state_nxt == S_DONE);
  assign mismatch = |(tag_core_q ^ tag_rx_q);
  assign mask_sh  = {5'd16 - O_pt_bytes, 3'b000};
  assign pt_mask  = {128{1'b1}} << mask_sh;

  // State register
  always_ff @(posedge crypto_clk) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: core handshakes take priority over the timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (I_start) state_nxt = bad_len ? S_DONE : S_INIT;
      end
      S_INIT: begin
        if (I_core_ready_for_data)
          state_nxt = (ad_bytes_q != 5'd0) ? S_AD : S_MSG;
        else if (timeout)
          state_nxt = S_DONE;
      end
      S_AD: begin
        if (I_core_read_data) state_nxt = S_MSG;
        else if (timeout)     state_nxt = S_DONE;
      end
      S_MSG: begin
        if (I_core_read_data) state_nxt = S_WAIT_TAG;
        else if (timeout)     state_nxt = S_DONE;
      end
      S_WAIT_TAG: begin
        if (I_core_ready_tag) state_nxt = S_CMP;
        else if (timeout)     state_nxt = S_DONE;
      end
      S_CMP:  state_nxt = S_DONE;
      S_DONE: begin
        if (!I_start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Core strobes and status decoded from the current state only
  always_comb begin
    O_core_data      = '0;
    O_core_bytes     = '0;
    O_core_valid     = 1'b0;
    O_core_last      = 1'b0;
    O_core_eot       = 1'b0;
    O_core_key_valid = 1'b0;
    O_core_decrypt   = 1'b0;
    O_busy           = 1'b0;
    O_trigger        = 1'b0;
    unique case (state)
      S_INIT: begin
        O_core_key_valid = 1'b1;
        O_core_decrypt   = 1'b1;
        O_busy           = 1'b1;
      end
      S_AD: begin
        O_core_data      = ad_q;
        O_core_bytes     = ad_bytes_q;
        O_core_valid     = 1'b1;
        O_core_last      = 1'b1;
        O_core_key_valid = 1'b1;
        O_core_decrypt   = 1'b1;
        O_busy           = 1'b1;
        O_trigger        = 1'b1;
      end
      S_MSG: begin
        O_core_data      = ct_q;
        O_core_bytes     = O_pt_bytes;
        O_core_valid     = 1'b1;
        O_core_last      = 1'b1;
        O_core_eot       = 1'b1;
        O_core_key_valid = 1'b1;
        O_core_decrypt   = 1'b1;
        O_busy           = 1'b1;
        O_trigger        = 1'b1;
      end
      S_WAIT_TAG: begin
        O_core_key_valid = 1'b1;
        O_core_decrypt   = 1'b1;
        O_busy           = 1'b1;
      end
      S_CMP:   O_busy = 1'b1;
      default: ;
    endcase
  end

  // Operand latching, capture, timeout counter and result flags
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      to_cnt     <= '0;
      ad_q       <= '0;
      ct_q       <= '0;
      tag_rx_q   <= '0;
      tag_core_q <= '0;
      pt_q       <= '0;
      ad_bytes_q <= '0;
      O_pt       <= '0;
      O_pt_bytes <= '0;
      O_done     <= 1'b0;
      O_tag_ok   <= 1'b0;
      O_err      <= 1'b0;
    end else begin
      O_done <= (state_nxt == S_DONE) & (state != S_DONE);
      if (state_nxt != state) to_cnt <= '0;
      else if (waiting)       to_cnt <= to_cnt + 1'b1;
      if (state == S_IDLE && I_start) begin
        ad_q       <= I_ad;
        ct_q       <= I_ct;
        tag_rx_q   <= I_tag;
        ad_bytes_q <= I_ad_bytes;
        O_pt_bytes <= I_ct_bytes;
        pt_q       <= '0;
        O_pt       <= '0;
        O_tag_ok   <= 1'b0;
        O_err      <= bad_len;
      end
      if ((state == S_MSG || state == S_WAIT_TAG) && I_core_out_valid)
        pt_q <= I_core_out & pt_mask;
      if (state == S_WAIT_TAG && I_core_ready_tag)
        tag_core_q <= I_core_tag;
      if (state == S_CMP) begin
        O_tag_ok <= ~mismatch;
        O_pt     <= mismatch ? '0 : pt_q;
      end
      if (to_fire) begin
        O_err    <= 1'b1;
        O_tag_ok <= 1'b0;
        O_pt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_dec_ctrl.sv
// Bench for ascon_dec_ctrl: behavioural core model, vector table,
// random vectors against a byte-level reference, and corner sequences.

module tb_ascon_dec_ctrl;

  logic         crypto_clk = 1'b0;
  logic         reset_i;
  logic         I_start;
  logic [127:0] I_ad, I_ct, I_tag;
  logic [4:0]   I_ad_bytes, I_ct_bytes;
  logic [127:0] O_core_data;
  logic [4:0]   O_core_bytes;
  logic         O_core_valid, O_core_last, O_core_eot;
  logic         O_core_key_valid, O_core_decrypt;
  logic         I_core_ready_for_data, I_core_read_data;
  logic         I_core_out_valid;
  logic [127:0] I_core_out;
  logic         I_core_ready_tag;
  logic [127:0] I_core_tag;
  logic [127:0] O_pt;
  logic [4:0]   O_pt_bytes;
  logic         O_busy, O_done, O_tag_ok, O_err, O_trigger;

  always #5 crypto_clk = ~crypto_clk;

  ascon_dec_ctrl #(.pTIMEOUT(16), .pTO_WIDTH(13)) dut (
    .crypto_clk(crypto_clk),
    .reset_i(reset_i),
    .I_start(I_start),
    .I_ad(I_ad),
    .I_ct(I_ct),
    .I_tag(I_tag),
    .I_ad_bytes(I_ad_bytes),
    .I_ct_bytes(I_ct_bytes),
    .O_core_data(O_core_data),
    .O_core_bytes(O_core_bytes),
    .O_core_valid(O_core_valid),
    .O_core_last(O_core_last),
    .O_core_eot(O_core_eot),
    .O_core_key_valid(O_core_key_valid),
    .O_core_decrypt(O_core_decrypt),
    .I_core_ready_for_data(I_core_ready_for_data),
    .I_core_read_data(I_core_read_data),
    .I_core_out_valid(I_core_out_valid),
    .I_core_out(I_core_out),
    .I_core_ready_tag(I_core_ready_tag),
    .I_core_tag(I_core_tag),
    .O_pt(O_pt),
    .O_pt_bytes(O_pt_bytes),
    .O_busy(O_busy),
    .O_done(O_done),
    .O_tag_ok(O_tag_ok),
    .O_err(O_err),
    .O_trigger(O_trigger)
  );

  localparam logic [127:0] TAG_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT_A5   = {16{8'hA5}};
  localparam logic [127:0] AD_K    = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] CT_K    = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;

  typedef struct {
    logic [4:0]   ad_b;
    logic [4:0]   ct_b;
    logic [127:0] ad;
    logic [127:0] ct;
    logic [127:0] tag_rx;
    logic [127:0] core_pt;
    logic [127:0] core_tag;
    logic         exp_ok;
    logic         exp_err;
    logic [127:0] exp_pt;
    logic [4:0]   exp_ptb;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic         m_en;
  logic [127:0] m_pt, m_tag;
  int           m_rd_dly, m_pt_dly, m_tag_dly;

  logic [275:0] all_out;
  assign all_out = {O_core_data, O_core_bytes, O_core_valid, O_core_last,
                    O_core_eot, O_core_key_valid, O_core_decrypt, O_pt,
                    O_pt_bytes, O_busy, O_done, O_tag_ok, O_err, O_trigger};

  task automatic chk(input string nm, input logic [275:0] act,
                     input logic [275:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] ad_b, ct_b,
                              input logic [127:0] tag_rx, core_pt, core_tag,
                              input logic ok, input logic [127:0] pt);
    vec_t v;
    v.ad_b = ad_b;       v.ct_b = ct_b;
    v.ad = AD_K;         v.ct = CT_K;
    v.tag_rx = tag_rx;   v.core_pt = core_pt;  v.core_tag = core_tag;
    v.exp_ok = ok;       v.exp_err = 1'b0;
    v.exp_pt = pt;       v.exp_ptb = ct_b;
    return v;
  endfunction

  // Reference: keep the first ct_b bytes; release only on exact tag match
  function automatic vec_t ref_fill(input vec_t v);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (i < int'(v.ct_b)) m[127-8*i -: 8] = v.core_pt[127-8*i -: 8];
    v.exp_err = 1'b0;
    v.exp_ok  = (v.tag_rx == v.core_tag);
    v.exp_pt  = v.exp_ok ? m : '0;
    v.exp_ptb = v.ct_b;
    return v;
  endfunction

  // Behavioural core: acks blocks after a delay, then returns pt and tag
  initial begin
    int wc, pc, ph;
    I_core_ready_for_data = 1'b1;
    I_core_read_data = 1'b0;
    I_core_out_valid = 1'b0;
    I_core_out = '0;
    I_core_ready_tag = 1'b0;
    I_core_tag = '0;
    wc = 0; pc = 0; ph = 0;
    forever begin
      @(negedge crypto_clk);
      if (m_en) begin
        I_core_read_data = 1'b0;
        I_core_out_valid = 1'b0;
        I_core_ready_tag = 1'b0;
        if (!O_busy) begin
          ph = 0; wc = 0; pc = 0;
        end else if (ph == 0) begin
          if (O_core_valid) begin
            if (wc >= m_rd_dly) begin
              I_core_read_data = 1'b1;
              wc = 0;
              if (O_core_eot) ph = 1;
            end else wc++;
          end
        end else if (ph == 1) begin
          pc++;
          if (pc == m_pt_dly) begin
            I_core_out_valid = 1'b1;
            I_core_out = m_pt;
          end
          if (pc == m_tag_dly) begin
            I_core_ready_tag = 1'b1;
            I_core_tag = m_tag;
            ph = 2;
          end
        end
      end
    end
  end

  task automatic run_op(input vec_t v, input string nm);
    int cyc, done_cnt, after;
    logic ad_seen, msg_seen, ad_bad, trig_bad;
    logic [4:0] msg_b;
    logic [127:0] msg_d;
    m_pt = v.core_pt;
    m_tag = v.core_tag;
    m_rd_dly = $urandom_range(0, 3);
    m_pt_dly = $urandom_range(1, 3);
    m_tag_dly = m_pt_dly + $urandom_range(0, 2);
    @(negedge crypto_clk);
    I_ad = v.ad; I_ct = v.ct; I_tag = v.tag_rx;
    I_ad_bytes = v.ad_b; I_ct_bytes = v.ct_b;
    I_start = 1'b1;
    @(negedge crypto_clk);
    I_start = 1'b0;
    cyc = 0; done_cnt = 0; after = 0;
    ad_seen = 0; msg_seen = 0; ad_bad = 0; trig_bad = 0;
    msg_b = '0; msg_d = '0;
    while (cyc < 200) begin
      if (O_core_valid && !O_core_eot) begin
        ad_seen = 1;
        if (O_core_data !== v.ad || O_core_bytes !== v.ad_b) ad_bad = 1;
      end
      if (O_core_valid && O_core_eot) begin
        msg_seen = 1;
        msg_b = O_core_bytes;
        msg_d = O_core_data;
      end
      if (O_trigger !== O_core_valid) trig_bad = 1;
      if (O_done) done_cnt++;
      if (done_cnt > 0) after++;
      if (after >= 3) break;
      @(negedge crypto_clk);
      cyc++;
    end
    chk({nm, " finished"}, 276'(cyc < 200), 276'(1));
    chk({nm, " done_pulses"}, 276'(done_cnt), 276'(1));
    chk({nm, " err"}, 276'(O_err), 276'(v.exp_err));
    chk({nm, " tag_ok"}, 276'(O_tag_ok), 276'(v.exp_ok));
    chk({nm, " pt"}, 276'(O_pt), 276'(v.exp_pt));
    chk({nm, " pt_bytes"}, 276'(O_pt_bytes), 276'(v.exp_ptb));
    chk({nm, " ad_phase"}, 276'(ad_seen), 276'(v.ad_b != 5'd0));
    chk({nm, " ad_block"}, 276'(ad_bad), 276'(0));
    chk({nm, " msg_phase"}, 276'(msg_seen), 276'(1));
    chk({nm, " msg_bytes"}, 276'(msg_b), 276'(v.ct_b));
    chk({nm, " msg_data"}, 276'(msg_d), 276'(v.ct));
    chk({nm, " trigger"}, 276'(trig_bad), 276'(0));
    chk({nm, " idle"}, 276'(O_busy), 276'(0));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int k, dc;
    logic strobe, err2;

    m_en = 1'b1;
    m_pt = '0; m_tag = '0;
    m_rd_dly = 0; m_pt_dly = 1; m_tag_dly = 1;
    reset_i = 1'b1;
    I_start = 1'b0;
    I_ad = '0; I_ct = '0; I_tag = '0;
    I_ad_bytes = '0; I_ct_bytes = '0;
    repeat (3) @(negedge crypto_clk);
    chk("reset outputs", all_out, '0);
    reset_i = 1'b0;
    @(negedge crypto_clk);
    chk("post-reset outputs", all_out, '0);

    tbl.push_back(mk(5'd16, 5'd16, TAG_SEQ, PT_A5, TAG_SEQ, 1'b1, PT_A5));
    tbl.push_back(mk(5'd16, 5'd16, TAG_SEQ ^ 128'd1, PT_A5, TAG_SEQ,
                     1'b0, '0));
    tbl.push_back(mk(5'd0, 5'd5, TAG_SEQ, PT_A5, TAG_SEQ, 1'b1,
                     {{5{8'hA5}}, 88'h0}));
    tbl.push_back(mk(5'd3, 5'd0, TAG_SEQ, PT_A5, TAG_SEQ, 1'b1, '0));
    tbl.push_back(mk(5'd1, 5'd16, TAG_SEQ ^ {1'b1, 127'd0}, PT_A5,
                     TAG_SEQ, 1'b0, '0));
    for (int i = 0; i < 10; i++) begin
      v.ad_b = 5'($urandom_range(0, 16));
      v.ct_b = 5'($urandom_range(0, 16));
      v.ad = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.core_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.core_tag = {$urandom(), $urandom(), $urandom(), $urandom()};
      v.tag_rx = v.core_tag;
      if ($urandom_range(0, 1) == 1)
        v.tag_rx = v.core_tag ^ (128'd1 << $urandom_range(0, 127));
      tbl.push_back(ref_fill(v));
    end
    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Oversized AD count: error without touching the core
    @(negedge crypto_clk);
    I_ad_bytes = 5'd17; I_ct_bytes = 5'd4; I_start = 1'b1;
    dc = 0; strobe = 0; err2 = 0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge crypto_clk);
      if (j == 2) begin
        err2 = O_err;
        I_start = 1'b0;
      end
      if (O_done) dc++;
      strobe |= O_core_valid | O_core_key_valid | O_core_eot
              | O_core_last | O_core_decrypt;
    end
    chk("badlen err", 276'(err2), 276'(1));
    chk("badlen done", 276'(dc), 276'(1));
    chk("badlen strobes", 276'(strobe), 276'(0));
    chk("badlen pt", 276'(O_pt), 276'(0));
    chk("badlen tag_ok", 276'(O_tag_ok), 276'(0));
    chk("badlen held", 276'(O_err), 276'(1));

    // Tag never arrives: timeout 16 cycles after entering WAIT_TAG
    m_en = 1'b0;
    I_core_read_data = 1'b0; I_core_out_valid = 1'b0;
    I_core_ready_tag = 1'b0; I_core_ready_for_data = 1'b1;
    @(negedge crypto_clk);
    I_ad = AD_K; I_ct = CT_K; I_tag = TAG_SEQ;
    I_ad_bytes = 5'd16; I_ct_bytes = 5'd16; I_start = 1'b1;
    @(negedge crypto_clk);
    I_start = 1'b0;
    @(negedge crypto_clk);
    chk("to ad state", 276'({O_core_valid, O_core_eot}), 276'(2'b10));
    I_core_read_data = 1'b1;
    @(negedge crypto_clk);
    chk("to msg state", 276'({O_core_valid, O_core_eot}), 276'(2'b11));
    @(negedge crypto_clk);
    I_core_read_data = 1'b0;
    I_core_out_valid = 1'b1;
    I_core_out = PT_A5;
    k = 0;
    while (!O_err && k < 40) begin
      @(negedge crypto_clk);
      I_core_out_valid = 1'b0;
      k++;
    end
    chk("to cycles", 276'(k), 276'(16));
    chk("to err", 276'(O_err), 276'(1));
    chk("to done", 276'(O_done), 276'(1));
    chk("to pt", 276'(O_pt), 276'(0));
    chk("to tag_ok", 276'(O_tag_ok), 276'(0));
    @(negedge crypto_clk);

    // Reset pulse while the CT block is presented
    I_start = 1'b1;
    @(negedge crypto_clk);
    I_start = 1'b0;
    @(negedge crypto_clk);
    I_core_read_data = 1'b1;
    @(negedge crypto_clk);
    I_core_read_data = 1'b0;
    chk("rst in msg", 276'({O_core_valid, O_core_eot}), 276'(2'b11));
    reset_i = 1'b1;
    @(negedge crypto_clk);
    reset_i = 1'b0;
    chk("rst outputs", all_out, '0);
    @(negedge crypto_clk);
    chk("rst stays idle", all_out, '0);
    m_en = 1'b1;
    run_op(tbl[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_dec_ctrl.md
# ascon_dec_ctrl

Sequencer for Ascon-128 authenticated decryption on the CW305 target: drives the Ascon core in decrypt mode through one associated-data block and one ciphertext block, captures the recovered plaintext and the computed tag, and checks that tag against the received tag. It sits between the register file (key, nonce, AD, CT and tag registers) and the core, and is the decrypt counterpart of the encrypt-side control FSM. Unverified plaintext is never released: on tag mismatch or error, the plaintext output is forced to zero.

## Interface
- pTIMEOUT, 4096: maximum cycles spent in any state that waits on the core before the block aborts.
- pTO_WIDTH, 13: width of the timeout counter; must hold pTIMEOUT.
- crypto_clk  in  1  single clock for the block and the core.
- reset_i  in  1  synchronous, active-high reset.
- I_start  in  1  level; a high sample in IDLE starts a decryption.
- I_ad, I_ct, I_tag  in  128 each  AD block, CT block, received tag; byte i sits at [127-8i -: 8].
- I_ad_bytes, I_ct_bytes  in  5 each  valid byte counts; legal range 0..16.
- O_core_data  out  128  block presented to the core.
- O_core_bytes  out  5  valid bytes of O_core_data.
- O_core_valid, O_core_last, O_core_eot  out  1 each  core data strobes.
- O_core_key_valid  out  1  key/nonce stable.
- O_core_decrypt  out  1  selects decrypt datapath.
- I_core_ready_for_data  in  1  core idle and able to initialise.
- I_core_read_data  in  1  one-cycle pulse: core consumed O_core_data.
- I_core_out_valid, I_core_out  in  1/128  recovered plaintext strobe and data.
- I_core_ready_tag, I_core_tag  in  1/128  computed tag ({tag2,tag1}) strobe and value.
- O_pt  out  128  plaintext; masked per operation rules.
- O_pt_bytes  out  5  equals I_ct_bytes latched at start.
- O_busy  out  1  high in every state except IDLE and DONE.
- O_done  out  1  one-cycle pulse on entry to DONE.
- O_tag_ok, O_err  out  1 each  result flags, held until next start.
- O_trigger  out  1  high during AD and MSG states (scope trigger).

## Operation
- States: IDLE, INIT, AD, MSG, WAIT_TAG, CMP, DONE.
- IDLE: all core strobes low. On I_start=1: latch I_ad, I_ct, I_tag and both byte counts; clear O_pt, O_tag_ok, O_err; go to INIT.
  - If either latched count exceeds 16: set O_err and go straight to DONE.
- INIT: O_core_key_valid=1.
  - When I_core_ready_for_data=1: go to AD if ad_bytes≠0, else to MSG (empty AD skips the AD phase).
- AD: O_core_data=AD, O_core_bytes=ad_bytes, valid=1, last=1, eot=0, key_valid=1, decrypt=1.
  - On I_core_read_data: go to MSG.
- MSG: O_core_data=CT, O_core_bytes=ct_bytes, valid=1, last=1, eot=1.
  - ct_bytes=0 is still presented as a single empty block.
  - On I_core_read_data: go to WAIT_TAG.
- Plaintext capture: I_core_out_valid in MSG or WAIT_TAG captures I_core_out into an internal register, zeroing bytes ≥ ct_bytes.
- WAIT_TAG: on I_core_ready_tag, capture I_core_tag and go to CMP.
  - If I_core_ready_tag and I_core_out_valid arrive in the same cycle, both are captured.
- CMP: one cycle.
  - mismatch = OR-reduction of (computed XOR received) over all 128 bits; constant time, no early exit.
  - O_tag_ok ← ~mismatch.
  - O_pt ← captured plaintext if tag_ok, else 0.
- DONE: O_done pulses for one cycle; outputs hold. Return to IDLE when I_start=0.
- Timeout: the counter clears on each state change and increments in INIT, AD, MSG and WAIT_TAG. On reaching pTIMEOUT: O_err=1, O_tag_ok=0, O_pt=0, go to DONE.
- I_start while busy is ignored.

## Timing
- Reset value of every output is 0; state=IDLE; counter=0.
- Reset mid-operation returns to IDLE on the next edge and drops all core strobes in that cycle.
- IDLE→INIT: one cycle after I_start is sampled.
- Core handshake: data and strobes stay stable until the I_core_read_data cycle. They are deasserted in the cycle after it.
- Result latency: O_tag_ok and O_pt are valid at the edge ending CMP, i.e. 2 cycles after I_core_ready_tag. O_done is high in that same next cycle.
- Controller overhead beyond core latency: 4 cycles.

## Test plan
- Core model returns tag 0x000102…0F and pt 0xA5 repeated; I_tag=0x000102…0F, ad_bytes=16, ct_bytes=16 -> O_tag_ok=1, O_pt=0xA5×16, O_done pulses once, O_err=0.
- Same stimulus with I_tag bit 0 flipped -> O_tag_ok=0, O_pt=0, O_err=0.
- ad_bytes=0, ct_bytes=5 -> AD state never entered; O_core_bytes=5 in MSG; O_pt upper 5 bytes = 0xA5, rest 0; O_pt_bytes=5.
- ad_bytes=17 -> O_err=1 two cycles after start, no core strobes asserted, O_done pulses.
- Core never asserts I_core_ready_tag, pTIMEOUT=16 -> O_err=1 exactly 16 cycles after entering WAIT_TAG, O_pt=0.
- reset_i for one cycle during MSG -> next cycle all outputs 0, state IDLE; a new I_start then completes normally.
